// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares the single data-memory port between the s4a pipeline memory stage
//   and a host/debug requester (program load, inspection, DMA-style pokes).
//   Pipeline accesses pass through combinationally with zero added latency.
//   Host accesses take pipe-idle slots. The host read response returns one
//   cycle after acceptance.
//
//   Optional feature macro: DATA_MEM_ARB_STARVATION_GUARD_EN
//     defined   : a wait counter tracks consecutive host-blocked cycles. On
//                 reaching MAX_WAIT, the arbiter steals one slot (STEAL) by
//                 raising pipe_stall for exactly one cycle. A pipeline access
//                 presented during STEAL sets the sticky arb_error flag.
//     undefined : no counter and no STEAL state. pipe_stall and arb_error
//                 are tied low, and the host may starve.
//
// Parameters
//   MAX_WAIT : host-blocked cycles before a slot is stolen (1..255)
//   ADDR_W   : address width
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   pipe_valid/is_mem/write      s4a qualifiers
//   pipe_addr/wdata/byte_en      s4a access fields
//   host_req_valid/ready         host request handshake
//   host_write/addr/wdata/byte_en host request fields
//   host_rsp_valid/rdata         host read response (1 cycle after accept)
//   pipe_stall                   registered one-cycle slot steal
//   mem_en/write/addr/wdata/byte_en  memory port
//   mem_rdata                    memory read data (1 cycle after read strobe)
//   arb_error                    sticky protocol-violation flag
module data_memory_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic              pipe_is_mem,
  input  logic              pipe_write,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [31:0]       pipe_wdata,
  input  logic [3:0]        pipe_byte_en,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_byte_en,
  output logic              host_rsp_valid,
  output logic [31:0]       host_rsp_rdata,
  output logic              pipe_stall,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byte_en,
  input  logic [31:0]       mem_rdata,
  output logic              arb_error
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("data_memory_arbiter: MAX_WAIT must be in 1..255");
  end

  logic pipe_act;
  logic host_owns;   // host has the port this cycle (if it is requesting)
  logic host_fire;
  logic rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  assign pipe_act = pipe_valid & pipe_is_mem;

`ifdef DATA_MEM_ARB_STARVATION_GUARD_EN
  typedef enum logic {NORMAL, STEAL} state_t;

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             stall_q;
  logic             err_q;
  logic             host_blocked;

  assign host_owns    = (state == STEAL) | ~pipe_act;
  assign host_blocked = host_req_valid & ~host_req_ready;

  // The transition happens on the edge where the counter reaches MAX_WAIT,
  // so the stolen slot is the cycle immediately after the MAX_WAIT-th
  // blocked cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= NORMAL;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          if (host_blocked) begin
            if (wait_cnt == LAST_CNT || wait_cnt == MAX_CNT) begin
              wait_cnt <= MAX_CNT;
              state    <= STEAL;
              stall_q  <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        STEAL: begin
          state    <= NORMAL;
          stall_q  <= 1'b0;
          wait_cnt <= '0;
          if (pipe_act) err_q <= 1'b1;
        end
        default: begin
          state   <= NORMAL;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_stall = stall_q;
  assign arb_error  = err_q;
`else
  assign host_owns  = ~pipe_act;
  assign pipe_stall = 1'b0;
  assign arb_error  = 1'b0;
`endif

  // Port mux. Reset gates both the handshake and the strobe.
  always_comb begin
    host_req_ready = reset & host_owns;
    mem_en         = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = pipe_addr;
    mem_wdata      = pipe_wdata;
    mem_byte_en    = pipe_byte_en;
    if (host_owns) begin
      mem_en      = reset & host_req_valid;
      mem_write   = reset & host_req_valid & host_write;
      mem_addr    = host_addr;
      mem_wdata   = host_wdata;
      mem_byte_en = host_byte_en;
    end else begin
      mem_en    = reset;
      mem_write = reset & pipe_write;
    end
  end

  assign host_fire = host_req_valid & host_req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= host_fire & ~host_write;
      if (rsp_valid_q) rsp_rdata_q <= mem_rdata;
    end
  end

  // Memory data arrives in the response cycle. It is forwarded in that
  // cycle and captured so the last read value stays on host_rsp_rdata.
  assign host_rsp_valid = rsp_valid_q;
  assign host_rsp_rdata = rsp_valid_q ? mem_rdata : rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  localparam int unsigned MAXW = 8;
  localparam int unsigned AW   = 32;

  logic          clock;
  logic          reset;
  logic          pipe_valid, pipe_is_mem, pipe_write;
  logic [AW-1:0] pipe_addr;
  logic [31:0]   pipe_wdata;
  logic [3:0]    pipe_byte_en;
  logic          host_req_valid, host_req_ready, host_write;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [3:0]    host_byte_en;
  logic          host_rsp_valid;
  logic [31:0]   host_rsp_rdata;
  logic          pipe_stall;
  logic          mem_en, mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byte_en;
  logic [31:0]   mem_rdata;
  logic          arb_error;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_arr [0:255];

  data_memory_arbiter #(.MAX_WAIT(MAXW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_is_mem(pipe_is_mem), .pipe_write(pipe_write),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_byte_en(pipe_byte_en),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_byte_en(host_byte_en),
    .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
    .pipe_stall(pipe_stall),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
    .arb_error(arb_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Word-addressed synchronous memory, read data one cycle after strobe.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem_arr[mem_addr[9:2]];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

`ifdef DATA_MEM_ARB_STARVATION_GUARD_EN
  // Hold a pipe load and a host read of 0x40 until the slot is stolen.
  // Returns at posedge+1 of the STEAL cycle.
  task automatic starve_until_steal(input string tag);
    pipe_valid = 1'b1; pipe_is_mem = 1'b1; pipe_write = 1'b0; pipe_addr = 32'h100;
    host_req_valid = 1'b1; host_write = 1'b0; host_addr = 32'h40;
    for (int c = 0; c < int'(MAXW); c++) begin
      #1;
      check_eq({tag, "_wait"}, {30'd0, pipe_stall, host_req_ready}, 32'd0);
      step;
    end
    check_eq({tag, "_stall"}, 32'(pipe_stall), 32'd1);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    mem_arr[32] = 32'h12345678;        // byte address 0x80
    mem_rdata = '0;
    reset = 1'b0;
    pipe_valid = 1'b0; pipe_is_mem = 1'b0; pipe_write = 1'b0;
    pipe_addr = '0; pipe_wdata = '0; pipe_byte_en = 4'hF;
    host_req_valid = 1'b1; host_write = 1'b0; host_addr = '0;
    host_wdata = '0; host_byte_en = 4'hF;
    #3;
    check_eq("rst_ready",     32'(host_req_ready), 32'd0);
    check_eq("rst_mem_en",    32'(mem_en),         32'd0);
    check_eq("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", host_rsp_rdata,      32'd0);
    check_eq("rst_stall",     32'(pipe_stall),     32'd0);
    check_eq("rst_err",       32'(arb_error),      32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    host_req_valid = 1'b0;
    step;

    // Host write then read on an idle pipeline
    host_req_valid = 1'b1; host_write = 1'b1; host_addr = 32'h40; host_wdata = 32'hDEADBEEF;
    #1;
    check_eq("wr_ready",     32'(host_req_ready), 32'd1);
    check_eq("wr_mem_en",    32'(mem_en),         32'd1);
    check_eq("wr_mem_write", 32'(mem_write),      32'd1);
    check_eq("wr_mem_addr",  mem_addr,            32'h40);
    check_eq("wr_mem_wdata", mem_wdata,           32'hDEADBEEF);
    step;
    host_write = 1'b0;
    #1;
    check_eq("rd_ready",     32'(host_req_ready), 32'd1);
    check_eq("rd_mem_write", 32'(mem_write),      32'd0);
    check_eq("wr_no_rsp",    32'(host_rsp_valid), 32'd0);
    step;
    host_req_valid = 1'b0;
    #1;
    check_eq("rd_rsp_valid", 32'(host_rsp_valid), 32'd1);
    check_eq("rd_rsp_rdata", host_rsp_rdata,      32'hDEADBEEF);
    check_eq("idle_mem_en",  32'(mem_en),         32'd0);
    step;
    #1;
    check_eq("rsp_pulse",    32'(host_rsp_valid), 32'd0);
    check_eq("rsp_hold",     host_rsp_rdata,      32'hDEADBEEF);

    // Pipe and host collide: pipe wins, host goes on first pipe-idle cycle
    pipe_valid = 1'b1; pipe_is_mem = 1'b1; pipe_write = 1'b0; pipe_addr = 32'h100;
    host_req_valid = 1'b1; host_write = 1'b0; host_addr = 32'h80;
    #1;
    check_eq("col_mem_addr", mem_addr,            32'h100);
    check_eq("col_ready",    32'(host_req_ready), 32'd0);
    check_eq("col_mem_en",   32'(mem_en),         32'd1);
    step;
    #1;
    check_eq("col_ready2",   32'(host_req_ready), 32'd0);
    pipe_is_mem = 1'b0;                 // valid non-memory op: slot is free
    #1;
    check_eq("free_ready",   32'(host_req_ready), 32'd1);
    check_eq("free_addr",    mem_addr,            32'h80);
    step;
    host_req_valid = 1'b0; pipe_valid = 1'b0;
    #1;
    check_eq("col_rsp_valid", 32'(host_rsp_valid), 32'd1);
    check_eq("col_rsp_rdata", host_rsp_rdata,      32'h12345678);

    // Pipe partial store passes straight through
    step;
    pipe_valid = 1'b1; pipe_is_mem = 1'b1; pipe_write = 1'b1;
    pipe_addr = 32'h44; pipe_wdata = 32'hA5A5A5A5; pipe_byte_en = 4'b0011;
    #1;
    check_eq("st_mem_write", 32'(mem_write),   32'd1);
    check_eq("st_byte_en",   32'(mem_byte_en), 32'h3);
    check_eq("st_wdata",     mem_wdata,        32'hA5A5A5A5);
    step;
    pipe_valid = 1'b0; pipe_write = 1'b0; pipe_byte_en = 4'hF;

    // Back-to-back host reads
    host_req_valid = 1'b1; host_write = 1'b0; host_addr = 32'h44;
    step;
    host_addr = 32'h40;
    #1;
    check_eq("b2b_ready",   32'(host_req_ready), 32'd1);
    check_eq("b2b_valid0",  32'(host_rsp_valid), 32'd1);
    check_eq("b2b_rdata0",  host_rsp_rdata,      32'h0000A5A5);
    step;
    host_req_valid = 1'b0;
    #1;
    check_eq("b2b_valid1",  32'(host_rsp_valid), 32'd1);
    check_eq("b2b_rdata1",  host_rsp_rdata,      32'hDEADBEEF);
    step;

`ifdef DATA_MEM_ARB_STARVATION_GUARD_EN
    // Round 1: pipeline honours the stall with a bubble
    starve_until_steal("st1");
    pipe_valid = 1'b0;
    #1;
    check_eq("st1_ready",    32'(host_req_ready), 32'd1);
    check_eq("st1_mem_addr", mem_addr,            32'h40);
    check_eq("st1_mem_en",   32'(mem_en),         32'd1);
    step;
    host_req_valid = 1'b0; pipe_valid = 1'b1;
    #1;
    check_eq("st1_rsp_valid", 32'(host_rsp_valid), 32'd1);
    check_eq("st1_rsp_rdata", host_rsp_rdata,      32'hDEADBEEF);
    check_eq("st1_unstall",   32'(pipe_stall),     32'd0);
    check_eq("st1_no_err",    32'(arb_error),      32'd0);
    step;

    // Round 2: pipeline violates the stall contract
    starve_until_steal("st2");
    #1;
    check_eq("st2_ready",    32'(host_req_ready), 32'd1);
    check_eq("st2_mem_addr", mem_addr,            32'h40);
    check_eq("st2_err_pre",  32'(arb_error),      32'd0);
    step;
    host_req_valid = 1'b0; pipe_valid = 1'b0;
    #1;
    check_eq("st2_err_set",  32'(arb_error),      32'd1);
    repeat (3) step;
    check_eq("st2_err_hold", 32'(arb_error),      32'd1);

    // Round 3: reset during STEAL with a host read accepted
    starve_until_steal("st3");
    pipe_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_eq("st3_rst_stall", 32'(pipe_stall),     32'd0);
    check_eq("st3_rst_ready", 32'(host_req_ready), 32'd0);
    check_eq("st3_rst_rsp",   32'(host_rsp_valid), 32'd0);
    check_eq("st3_rst_en",    32'(mem_en),         32'd0);
    check_eq("st3_rst_err",   32'(arb_error),      32'd0);
    @(posedge clock);
    host_req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step;
    check_eq("st3_no_rsp0",   32'(host_rsp_valid), 32'd0);
    step;
    check_eq("st3_no_rsp1",   32'(host_rsp_valid), 32'd0);
    check_eq("st3_stall_lo",  32'(pipe_stall),     32'd0);
`else
    // Continuous pipeline memory traffic starves the host
    pipe_valid = 1'b1; pipe_is_mem = 1'b1; pipe_write = 1'b0; pipe_addr = 32'h100;
    host_req_valid = 1'b1; host_write = 1'b0; host_addr = 32'h40;
    for (int c = 0; c < 100; c++) begin
      #1;
      check_eq("starve", {30'd0, pipe_stall, host_req_ready}, 32'd0);
      step;
    end
    check_eq("starve_err", 32'(arb_error), 32'd0);
    pipe_valid = 1'b0;
    #1;
    check_eq("starve_release", 32'(host_req_ready), 32'd1);
    step;
    host_req_valid = 1'b0;
    #1;
    check_eq("starve_rsp", host_rsp_rdata, 32'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
